univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal register that generalises the single-bit asynchronously presettable D flip-flop to a WIDTH-bit register. It supports hold, parallel load, logical shift left/right, rotate, and up/down counting. It is the general-purpose state element for lab datapaths (serial links, LFSR seeds, event counters) wherever a preset-to-known-value register with selectable next-state function is required.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64
- PRESET_VAL, {WIDTH{1'b1}}, value forced onto q while preset is high
- clock  in  1  rising-edge clock
- preset  in  1  asynchronous, active-high reset; forces q = PRESET_VAL
- sclr  in  1  synchronous clear to 0; priority over en and mode
- en  in  1  next-state enable; when 0, q holds regardless of mode
- mode  in  3  next-state function select (see Operation)
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial in, enters MSB on shift right
- sin_r  in  1  serial in, enters bit 0 on shift left
- q  out  WIDTH  registered state
- sout_l  out  1  q[WIDTH-1], combinational from q
- sout_r  out  1  q[0], combinational from q
- wrap  out  1  registered one-cycle pulse on counter wrap

## Operation
- Priority at each rising clock edge: preset (async) > sclr > en=0 (hold) > mode.
- mode encoding with en=1 and sclr=0:
  - 000: hold, q unchanged
  - 001: load, q <= d
  - 010: shift left, q <= {q[WIDTH-2:0], sin_r}
  - 011: shift right, q <= {sin_l, q[WIDTH-1:1]}
  - 100: rotate left, q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - 101: rotate right, q <= {q[0], q[WIDTH-1:1]}
  - 110: count up, q <= q + 1 modulo 2^WIDTH
  - 111: count down, q <= q - 1 modulo 2^WIDTH
- wrap is 1 for exactly the cycle after an edge where:
  - mode=110, en=1, sclr=0, and q was all ones (q becomes 0); or
  - mode=111, en=1, sclr=0, and q was 0 (q becomes all ones).
- wrap is 0 after every other edge, including hold, sclr, and non-count modes.
- sclr with en=0 still clears q to 0. wrap is 0 after that edge.
- Arithmetic is unsigned at WIDTH bits. There is no saturation. The carry is visible only via wrap.

## Timing
- Reset values: while preset=1, q = PRESET_VAL and wrap = 0. sout_l and sout_r follow q (PRESET_VAL MSB/LSB).
- preset assertion takes effect immediately, without a clock. This applies mid-shift and mid-count; any in-progress operation is discarded.
- preset deassertion is sampled: the first edge with preset=0 applies the normal next-state function to q = PRESET_VAL.
- Latency: one clock from sampled inputs to q and wrap. sout_l and sout_r have zero latency from q.
- All inputs except preset are sampled on the rising edge only. Glitches between edges have no effect.
- preset must deassert synchronously to clock (externally synchronised). The block contains no reset synchroniser.

## Configuration
- USR_PARITY_EN defined:
  - Adds output port parity (1 bit) = XOR of all q bits, combinational from q.
  - parity equals ^PRESET_VAL during preset.
- USR_PARITY_EN undefined:
  - The parity port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8 and PRESET_VAL=8'hFF.
- Preset and load: assert preset mid-cycle -> q=8'hFF immediately, wrap=0. Release preset, then load d=8'hA5 -> q=8'hA5 one edge later.
- Shift both directions: from q=8'h81, mode=010 with sin_r=0 -> q=8'h02. Then mode=011 with sin_l=1 -> q=8'h81. sout_l and sout_r track q each cycle.
- Rotate round trip: q=8'h01, 8 edges of mode=100 -> q=8'h01, passing through 8'h80 after the 7th edge. mode=101 restores the same sequence in reverse.
- Count up through wrap: from q=8'hFE, two count-up edges -> q=8'hFF then 8'h00, with wrap=1 only in the cycle showing 8'h00.
- Count down through wrap: from q=8'h00, count down -> q=8'hFF with wrap=1 for one cycle. The next edge gives q=8'hFE and wrap=0.
- Priority and parity: with sclr=1, en=0, and q=8'h3C -> q=8'h00. With en=0 and mode=001, q holds. Assert preset together with sclr -> q=8'hFF. If USR_PARITY_EN is defined, check parity=0 at 8'hFF and parity=1 at 8'h01.

Source files
------------

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//
// WIDTH-bit universal register with an asynchronous preset. Each rising
// clock edge applies one selectable next-state function: hold, parallel
// load, logical shift left/right, rotate left/right, or count up/down.
// It is a general-purpose state element for serial links, LFSR seeds and
// event counters.
//
// Optional feature: define USR_PARITY_EN to add the 'parity' output. It
// carries the XOR of all q bits and is derived combinationally from q.
//
// Parameters
//   WIDTH       register width in bits (2..64)
//   PRESET_VAL  value forced onto q while preset is high
//
// Ports
//   clock   in   rising-edge clock
//   preset  in   asynchronous active-high preset, q = PRESET_VAL
//   sclr    in   synchronous clear to 0; wins over en and mode
//   en      in   next-state enable; 0 holds q
//   mode    in   next-state function select
//   d       in   parallel load data
//   sin_l   in   serial input entering the MSB on shift right
//   sin_r   in   serial input entering bit 0 on shift left
//   q       out  registered state
//   sout_l  out  q[WIDTH-1]
//   sout_r  out  q[0]
//   wrap    out  registered one-cycle pulse when the counter wraps
//   parity  out  ^q (present only with USR_PARITY_EN)
// ---------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             preset,
    input  logic             sclr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
`ifdef USR_PARITY_EN
    output logic             wrap,
    output logic             parity
`else
    output logic             wrap
`endif
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_UP   = 3'b110,
        MODE_DOWN = 3'b111
    } mode_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    // Next-state selection. The priority order is sclr, then enable,
    // then mode. wrap_nxt is raised only on the two counter wrap cases.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (sclr) begin
            q_nxt = ZERO;
        end else if (en) begin
            case (mode_t'(mode))
                MODE_HOLD: q_nxt = q;
                MODE_LOAD: q_nxt = d;
                MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_r};
                MODE_SHR:  q_nxt = {sin_l, q[WIDTH-1:1]};
                MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
                MODE_UP: begin
                    q_nxt    = q + ONE;
                    wrap_nxt = (q == ONES);
                end
                MODE_DOWN: begin
                    q_nxt    = q - ONE;
                    wrap_nxt = (q == ZERO);
                end
                default: q_nxt = q;
            endcase
        end
    end

    // State register. The preset acts immediately and discards any
    // shift or count that is in progress.
    always_ff @(posedge clock or posedge preset) begin
        if (preset) begin
            q    <= PRESET_VAL;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

`ifdef USR_PARITY_EN
    assign parity = ^q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Bench for univ_shift_reg with WIDTH=8 and PRESET_VAL=8'hFF.
//
// The reference model keeps the register as an integer and applies each
// operation with plain arithmetic on that integer: multiply or divide by
// two for shifts, modulo 256 for counting. A directed sequence runs first,
// followed by a block of random steps.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         preset;
    logic         sclr;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_l;
    logic         sin_r;
    logic [W-1:0] q;
    logic         sout_l;
    logic         sout_r;
    logic         wrap;
`ifdef USR_PARITY_EN
    logic         parity;
`endif

    int total = 0;
    int bad   = 0;

    int m;      // model register value, range 0..255
    int mw;     // model wrap flag

    univ_shift_reg #(.WIDTH(W), .PRESET_VAL(8'hFF)) dut (
        .clock  (clock),
        .preset (preset),
        .sclr   (sclr),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
`ifdef USR_PARITY_EN
        .wrap   (wrap),
        .parity (parity)
`else
        .wrap   (wrap)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ones_parity(input int v);
        int p = 0;
        for (int i = 0; i < W; i++) p = p + ((v >> i) % 2);
        return p % 2;
    endfunction

    // Compare every DUT output against the model.
    task automatic chk_all(input string tag);
        chk({tag, ".q"}, 64'(q), 64'(m));
        chk({tag, ".wrap"}, 64'(wrap), 64'(mw));
        chk({tag, ".sout_l"}, 64'(sout_l), 64'(m / 128));
        chk({tag, ".sout_r"}, 64'(sout_r), 64'(m % 2));
`ifdef USR_PARITY_EN
        chk({tag, ".parity"}, 64'(parity), 64'(ones_parity(m)));
`endif
    endtask

    // Apply the inputs, advance one rising edge, update the model and
    // check the outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic s_clr, input logic s_en,
                        input logic [2:0] s_mode, input int s_d,
                        input logic s_l, input logic s_r);
        sclr  = s_clr;
        en    = s_en;
        mode  = s_mode;
        d     = W'(s_d);
        sin_l = s_l;
        sin_r = s_r;
        @(posedge clock);
        mw = 0;
        if (s_clr) begin
            m = 0;
        end else if (s_en) begin
            case (s_mode)
                3'd1: m = s_d % 256;
                3'd2: m = (m * 2) % 256 + int'(s_r);
                3'd3: m = m / 2 + 128 * int'(s_l);
                3'd4: m = (m * 2) % 256 + m / 128;
                3'd5: m = m / 2 + 128 * (m % 2);
                3'd6: begin mw = (m == 255); m = (m + 1) % 256; end
                3'd7: begin mw = (m == 0); m = (m + 255) % 256; end
                default: ;
            endcase
        end
        #1;
        chk_all(tag);
    endtask

    // Raise preset between edges and check its immediate effect. Then
    // release it 1 time unit after the next rising edge.
    task automatic pulse_preset(input string tag);
        @(negedge clock);
        #1 preset = 1'b1;
        #1;
        m  = 255;
        mw = 0;
        chk_all({tag, ".async"});
        @(posedge clock);
        #1;
        chk_all({tag, ".held"});
        preset = 1'b0;
    endtask

    initial begin
        preset = 1'b1;
        sclr   = 1'b0;
        en     = 1'b0;
        mode   = 3'd0;
        d      = '0;
        sin_l  = 1'b0;
        sin_r  = 1'b0;
        m      = 255;
        mw     = 0;

        // Reset state.
        #2;
        chk_all("reset");
        @(posedge clock);
        #1 preset = 1'b0;

        // Load after release.
        step("load_a5", 0, 1, 3'd1, 'hA5, 0, 0);
        chk("load_a5_lit", 64'(q), 64'h0A5);

        // Shift in both directions.
        step("load_81", 0, 1, 3'd1, 'h81, 0, 0);
        step("shl", 0, 1, 3'd2, 0, 0, 0);
        chk("shl_lit", 64'(q), 64'h02);
        step("shr", 0, 1, 3'd3, 0, 1, 0);
        chk("shr_lit", 64'(q), 64'h81);

        // Rotate a full round trip in each direction.
        step("load_01", 0, 1, 3'd1, 'h01, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step("rol", 0, 1, 3'd4, 0, 0, 0);
            if (i == 7) chk("rol7_lit", 64'(q), 64'h80);
        end
        chk("rol8_lit", 64'(q), 64'h01);
        for (int i = 1; i <= 8; i++) begin
            step("ror", 0, 1, 3'd5, 0, 0, 0);
            if (i == 1) chk("ror1_lit", 64'(q), 64'h80);
        end
        chk("ror8_lit", 64'(q), 64'h01);

        // Count up through the wrap.
        step("load_fe", 0, 1, 3'd1, 'hFE, 0, 0);
        step("up1", 0, 1, 3'd6, 0, 0, 0);
        chk("up1_wrap_lit", 64'(wrap), 64'd0);
        step("up2", 0, 1, 3'd6, 0, 0, 0);
        chk("up2_wrap_lit", 64'(wrap), 64'd1);
        step("hold_after_wrap", 0, 1, 3'd0, 0, 0, 0);

        // Count down through the wrap.
        step("down1", 0, 1, 3'd7, 0, 0, 0);
        chk("down1_wrap_lit", 64'(wrap), 64'd1);
        step("down2", 0, 1, 3'd7, 0, 0, 0);
        chk("down2_lit", 64'(q), 64'hFE);

        // Preset raised mid-cycle while wrap is high.
        step("load_ff", 0, 1, 3'd1, 'hFF, 0, 0);
        step("up_wrap", 0, 1, 3'd6, 0, 0, 0);
        pulse_preset("preset_mid");

        // Priority checks.
        step("load_3c", 0, 1, 3'd1, 'h3C, 0, 0);
        step("sclr_en0", 1, 0, 3'd1, 'h55, 0, 0);
        chk("sclr_lit", 64'(q), 64'h00);
        step("load_3c_b", 0, 1, 3'd1, 'h3C, 0, 0);
        step("en0_hold", 0, 0, 3'd1, 'h55, 0, 0);
        chk("en0_hold_lit", 64'(q), 64'h3C);
        step("sclr_on_count", 1, 1, 3'd7, 0, 0, 0);
        sclr = 1'b1;
        pulse_preset("preset_sclr");
        step("after_preset", 0, 1, 3'd6, 0, 0, 0);
        chk("after_preset_wrap_lit", 64'(wrap), 64'd1);
`ifdef USR_PARITY_EN
        step("par_ff", 0, 1, 3'd1, 'hFF, 0, 0);
        chk("par_ff_lit", 64'(parity), 64'd0);
        step("par_01", 0, 1, 3'd1, 'h01, 0, 0);
        chk("par_01_lit", 64'(parity), 64'd1);
`endif

        // Random steps with occasional preset pulses.
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 49) begin
                pulse_preset("rnd_preset");
            end else begin
                step("rnd",
                     ($urandom_range(9) == 0),
                     ($urandom_range(4) != 0),
                     3'($urandom_range(7)),
                     int'($urandom_range(255)),
                     1'($urandom_range(1)),
                     1'($urandom_range(1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
